// File: rtl/fetch_stage.sv
// IF stage: PC, instruction-memory req/ack fetch, IF/ID register, stalls and branch redirect.
// Optional macro IFID_FLUSH_EN: a taken branch squashes IF/ID regardless of IF_ID_Write.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetManual,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCOutput,
  output logic [31:0] ALUPCPlus4Output,
  output logic [31:0] PIPE_IFID_ALUPCPlus4Output,
  output logic [31:0] PIPE_IFID_Instruction,
  output logic        PIPE_IFID_Valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_buf;
  logic [XLEN-1:0]   r_drain_addr;
  logic              r_started;
  logic [XLEN-1:0]   r_ifid_pc4;
  logic [XLEN-1:0]   r_ifid_instr;
  logic              r_ifid_valid;

  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_target;
  logic              w_req;
  logic              w_ack;
  logic              w_advance;
  logic              w_flush;
  logic              w_unused;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_target   = {branchTarget[31:2], 2'b00};
  assign w_unused   = ^branchTarget[1:0];
  // No request in the first cycle after reset release; acks then are ignored.
  assign w_req      = r_started && (r_state != HOLD);
  assign w_ack      = w_req && imem_ack;
  assign w_advance  = (r_state == HOLD) && PCWrite && IF_ID_Write && !branchTaken;

`ifdef IFID_FLUSH_EN
  assign w_flush = branchTaken;
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetManual) begin
    if (!resetManual) r_state <= FETCH;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: begin
        if (branchTaken)  w_next_state = (w_req && !imem_ack) ? DRAIN : FETCH;
        else if (w_ack)   w_next_state = HOLD;
      end
      HOLD: begin
        if (branchTaken || w_advance) w_next_state = FETCH;
      end
      DRAIN: begin
        if (w_ack) w_next_state = FETCH;
      end
      default: w_next_state = FETCH;
    endcase
  end

  // While draining, the stale request keeps its original address.
  always_comb begin
    imem_req  = w_req;
    imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;
  end

  always_ff @(posedge clk or negedge resetManual) begin
    if (!resetManual) begin
      r_pc         <= RESET_PC;
      r_buf        <= NOP_WORD;
      r_drain_addr <= RESET_PC;
      r_started    <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (branchTaken)    r_pc <= w_target;
      else if (w_advance) r_pc <= w_pc_plus4;
      if ((r_state == FETCH) && w_ack && !branchTaken) r_buf <= imem_rdata;
      if ((r_state == FETCH) && branchTaken && w_req && !imem_ack) r_drain_addr <= r_pc;
    end
  end

  // IF/ID loads the buffered instruction only on a real advance, otherwise a bubble.
  always_ff @(posedge clk or negedge resetManual) begin
    if (!resetManual) begin
      r_ifid_pc4   <= '0;
      r_ifid_instr <= NOP_WORD;
      r_ifid_valid <= 1'b0;
    end else if (w_flush || IF_ID_Write) begin
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_instr <= w_advance ? r_buf : NOP_WORD;
      r_ifid_valid <= w_advance;
    end
  end

  assign PCOutput                   = r_pc;
  assign ALUPCPlus4Output           = w_pc_plus4;
  assign PIPE_IFID_ALUPCPlus4Output = r_ifid_pc4;
  assign PIPE_IFID_Instruction      = r_ifid_instr;
  assign PIPE_IFID_Valid            = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed and random stimulus, reference model feeding a scoreboard queue.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetManual;
  logic        PCWrite, IF_ID_Write, branchTaken, imem_ack;
  logic [31:0] branchTarget, imem_rdata;
  logic        imem_req, PIPE_IFID_Valid;
  logic [31:0] imem_addr, PCOutput, ALUPCPlus4Output;
  logic [31:0] PIPE_IFID_ALUPCPlus4Output, PIPE_IFID_Instruction;

  fetch_stage dut (
    .clk(clk), .resetManual(resetManual), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .PCOutput(PCOutput), .ALUPCPlus4Output(ALUPCPlus4Output),
    .PIPE_IFID_ALUPCPlus4Output(PIPE_IFID_ALUPCPlus4Output),
    .PIPE_IFID_Instruction(PIPE_IFID_Instruction), .PIPE_IFID_Valid(PIPE_IFID_Valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] pc4f;
    logic [31:0] instr;
    logic        valid;
    logic        req;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: architectural PC, whether an instruction is buffered,
  // whether a stale request must be discarded, and the IF/ID contents.
  logic [31:0] m_pc, m_buf, m_daddr, m_pc4f, m_instr;
  logic        m_have, m_drain, m_started, m_valid;

  function automatic logic m_req();
    return m_started && !m_have;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_daddr : m_pc;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h2000_0000;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_buf = NOP; m_daddr = 32'h0;
    m_pc4f = 32'h0; m_instr = NOP; m_valid = 1'b0;
    m_have = 1'b0; m_drain = 1'b0; m_started = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (called at a negedge), advance the model, queue the expectation.
  task automatic step(input logic pcw, input logic ifw, input logic br,
                      input logic [31:0] tgt, input logic ack);
    logic  req, ack_eff, real_load;
    exp_t  e;
    req       = m_req();
    ack_eff   = req && ack;
    real_load = m_have && pcw && ifw && !br;
    PCWrite      = pcw;
    IF_ID_Write  = ifw;
    branchTaken  = br;
    branchTarget = tgt;
    imem_ack     = ack;
    imem_rdata   = ack ? mem_word(m_addr()) : 32'hDEAD_BEEF;

`ifdef IFID_FLUSH_EN
    if (br || ifw) begin
`else
    if (ifw) begin
`endif
      m_pc4f  = m_pc + 32'd4;
      m_instr = real_load ? m_buf : NOP;
      m_valid = real_load;
    end

    if (br) begin
      if (req && !ack) begin
        if (!m_drain) m_daddr = m_pc;
        m_drain = 1'b1;
      end else begin
        m_drain = 1'b0;
      end
      m_have = 1'b0;
      m_pc   = tgt & 32'hFFFF_FFFC;
    end else if (m_drain) begin
      if (ack_eff) m_drain = 1'b0;
    end else if (!m_have && ack_eff) begin
      m_have = 1'b1;
      m_buf  = mem_word(m_pc);
    end else if (real_load) begin
      m_pc   = m_pc + 32'd4;
      m_have = 1'b0;
    end
    m_started = 1'b1;

    e.pc = m_pc; e.addr = m_addr(); e.pc4f = m_pc4f; e.instr = m_instr;
    e.valid = m_valid; e.req = m_req();
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_pc",    PCOutput, 32'h0);
    chk("rst_pc4",   ALUPCPlus4Output, 32'h4);
    chk("rst_ifpc4", PIPE_IFID_ALUPCPlus4Output, 32'h0);
    chk("rst_instr", PIPE_IFID_Instruction, NOP);
    chk("rst_valid", {31'b0, PIPE_IFID_Valid}, 32'h0);
  endtask

  // Monitor: compare DUT state after every edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",        PCOutput, e.pc);
        chk("pc_plus4",  ALUPCPlus4Output, e.pc + 32'd4);
        chk("imem_req",  {31'b0, imem_req}, {31'b0, e.req});
        if (e.req) chk("imem_addr", imem_addr, e.addr);
        chk("ifid_pc4",  PIPE_IFID_ALUPCPlus4Output, e.pc4f);
        chk("ifid_instr", PIPE_IFID_Instruction, e.instr);
        chk("ifid_valid", {31'b0, PIPE_IFID_Valid}, {31'b0, e.valid});
      end
    end
  end

  initial begin
    resetManual = 1'b0;
    PCWrite = 1'b0; IF_ID_Write = 1'b0; branchTaken = 1'b0;
    branchTarget = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    resetManual = 1'b1;

    // Ack in the first cycle after release has no request behind it.
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, m_req());
    step(1'b1, 1'b1, 1'b0, 32'h0, m_req());
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect from HOLD: buffered word must never reach IF/ID.
    step(1'b1, 1'b1, 1'b0, 32'h0, m_req());
    step(1'b1, 1'b1, 1'b1, 32'h0000_0043, 1'b0);

    // Redirect while a request is outstanding, ack three cycles late.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, m_req());

    // Second redirect during drain: last target wins.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0301, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect with ack in the same cycle discards that ack.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b1);

    // PC wrap-around at the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, m_req());
    step(1'b1, 1'b1, 1'b0, 32'h0, m_req());

    // Branch with IF_ID_Write=0 in HOLD (flush behaviour depends on build).
    step(1'b1, 1'b1, 1'b0, 32'h0, m_req());
    step(1'b1, 1'b1, 1'b0, 32'h0, m_req());
    step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, m_req());

    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'hFFFF_FFC0;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), tgt,
           m_req() && ($urandom_range(0, 1) == 0));
    end

    // Reset with a request outstanding, then a stale ack right after release.
    while (!(m_req() && !m_have)) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    resetManual = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    resetManual = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, m_req());

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
